// File: rtl/puf_auth_controller.sv
// puf_auth_controller: drives the arbiter PUF, majority-votes VOTES evaluations and scores the result against the enrolled response
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_challenge/req_expected host request;
//   puf_reset/puf_enable/puf_challenge/puf_resp PUF macro side (puf_resp is asynchronous to clk);
//   res_valid/res_ready/res_response/res_hd/res_pass result handshake.
// Optional: define PUF_AUTH_STATS_EN to add saturating stat_auth_cnt, stat_fail_cnt, stat_unstable_cnt.
module puf_auth_controller #(
  parameter int C_BITS = 4,
  parameter int R_BITS = 4,
  parameter int SETTLE = 8,
  parameter int VOTES = 3,
  parameter int TOL = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [C_BITS-1:0]             req_challenge,
  input  logic [R_BITS-1:0]             req_expected,
  output logic                          puf_reset,
  output logic                          puf_enable,
  output logic [C_BITS-1:0]             puf_challenge,
  input  logic [R_BITS-1:0]             puf_resp,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [R_BITS-1:0]             res_response,
  output logic [$clog2(R_BITS+1)-1:0]   res_hd,
  output logic                          res_pass
`ifdef PUF_AUTH_STATS_EN
  ,
  output logic [15:0]                   stat_auth_cnt,
  output logic [15:0]                   stat_fail_cnt,
  output logic [15:0]                   stat_unstable_cnt
`endif
);
  localparam int HW = $clog2(R_BITS+1);
  localparam int TW = $clog2(SETTLE);
  localparam int VW = $clog2(VOTES+1);
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RELAX, REPORT} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr;
  logic [VW-1:0] votes;
  logic [VW-1:0] ones [R_BITS];
  logic [R_BITS-1:0] sync_a, sync_b, exp_q, maj;
  logic [HW-1:0] hd_n;
  logic tmr_end, accept, done;
  assign tmr_end = tmr == TW'(SETTLE-1);
  assign accept = req_valid && req_ready;
  assign done = res_valid && res_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? CLEAR : IDLE;
      CLEAR:   state_n = LAUNCH;
      LAUNCH:  state_n = tmr_end ? RELAX : LAUNCH;
      RELAX:   state_n = tmr_end ? (votes < VW'(VOTES) ? CLEAR : REPORT) : RELAX;
      REPORT:  state_n = res_ready ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
  end
  // Outputs decode from state so an async reset forces them safe immediately.
  always_comb begin
    req_ready = state == IDLE;
    puf_enable = state == LAUNCH;
    puf_reset = reset || state == CLEAR;
    res_valid = state == REPORT;
  end
  always_comb begin
    maj = '0;
    hd_n = '0;
    for (int k = 0; k < R_BITS; k++) begin
      maj[k] = ones[k] > VW'(VOTES/2);
      hd_n = hd_n + HW'(maj[k] ^ exp_q[k]);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      tmr <= '0;
      votes <= '0;
      exp_q <= '0;
      puf_challenge <= '0;
      res_response <= '0;
      res_hd <= '0;
      res_pass <= 1'b0;
      for (int k = 0; k < R_BITS; k++) ones[k] <= '0;
    end else begin
      sync_a <= puf_resp;
      sync_b <= sync_a;
      tmr <= ((state == LAUNCH || state == RELAX) && !tmr_end) ? tmr + 1'b1 : '0;
      if (accept) begin
        puf_challenge <= req_challenge;
        exp_q <= req_expected;
        votes <= '0;
        for (int k = 0; k < R_BITS; k++) ones[k] <= '0;
      end
      // Sample on the last enable cycle: the arbiters have had SETTLE cycles, minus sync latency.
      if (state == LAUNCH && tmr_end) begin
        votes <= votes + 1'b1;
        for (int k = 0; k < R_BITS; k++) ones[k] <= ones[k] + VW'(sync_b[k]);
      end
      if (state == RELAX && state_n == REPORT) begin
        res_response <= maj;
        res_hd <= hd_n;
        res_pass <= (32'(hd_n) <= TOL);
      end
      if (done) puf_challenge <= '0;
    end
`ifdef PUF_AUTH_STATS_EN
  logic unstable;
  always_comb begin
    unstable = 1'b0;
    for (int k = 0; k < R_BITS; k++) unstable = unstable || (ones[k] != '0 && ones[k] != VW'(VOTES));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_auth_cnt <= '0;
      stat_fail_cnt <= '0;
      stat_unstable_cnt <= '0;
    end else if (done) begin
      if (stat_auth_cnt != 16'hFFFF) stat_auth_cnt <= stat_auth_cnt + 16'd1;
      if (!res_pass && stat_fail_cnt != 16'hFFFF) stat_fail_cnt <= stat_fail_cnt + 16'd1;
      if (unstable && stat_unstable_cnt != 16'hFFFF) stat_unstable_cnt <= stat_unstable_cnt + 16'd1;
    end
`endif
endmodule
